// File: rtl/rfphoenix_icache_fill_if.sv
// Memory read port of the I$ fill controller: one 128-bit beat per mem_ack.
interface rfphoenix_icache_fill_if #(
  parameter int AWID = 32
);
  logic            mem_req;
  logic [AWID-1:0] mem_adr;
  logic            mem_ack;
  logic            mem_err;
  logic [127:0]    mem_dat;

  modport master (output mem_req, mem_adr, input mem_ack, mem_err, mem_dat);
  modport slave  (input mem_req, mem_adr, output mem_ack, mem_err, mem_dat);
endinterface

// File: rtl/rfphoenix_icache_fill.sv
// I$ miss/fill controller: picks a victim way, fetches a 64-byte line in four
// beats, writes it into the arrays and owns the per-way valid bits.
module rfphoenix_icache_fill #(
  parameter  int LINES = 128,
  parameter  int WAYS  = 4,
  parameter  int AWID  = 32,
  localparam int IW    = $clog2(LINES),
  localparam int WW    = $clog2(WAYS),
  localparam int TW    = AWID - 6
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        miss,
  input  logic [AWID-1:0]             miss_adr,
  input  logic                        invall,
  input  logic                        invline,
  input  logic [AWID-1:0]             inv_adr,
  rfphoenix_icache_fill_if.master     mem,
  output logic                        wr_en,
  output logic [WW-1:0]               wr_way,
  output logic [IW-1:0]               wr_idx,
  output logic [TW-1:0]               wr_tag,
  output logic [511:0]                wr_line,
  output logic [WAYS-1:0][LINES-1:0]  valid,
  output logic                        busy,
  output logic                        done,
  output logic                        err
);

  typedef enum logic [1:0] {IDLE, FETCH, WRITE} state_t;

  state_t                     state_q, state_d;
  logic [1:0]                 beat_q, beat_d;
  logic [TW-1:0]              tag_q, tag_d;
  logic [WW-1:0]              way_q, way_d;
  logic [WW-1:0]              rr_q, rr_d;
  logic                       allv_q, allv_d;
  logic [3:0][127:0]          line_q, line_d;
  logic [WAYS-1:0][LINES-1:0] valid_q, valid_d;
  logic                       mem_req_q, mem_req_d;
  logic [AWID-1:0]            mem_adr_q, mem_adr_d;
  logic                       wr_en_q, wr_en_d;
  logic                       done_q, done_d;
  logic                       err_q, err_d;
  logic                       busy_q, busy_d;

  logic [IW-1:0] miss_idx, inv_idx;
  logic [1:0]    beat_inc;
  logic          free_found;
  logic [WW-1:0] free_way;

  assign miss_idx = miss_adr[6 +: IW];
  assign inv_idx  = inv_adr[6 +: IW];
  assign beat_inc = beat_q + 2'd1;

  // Low address bits never reach the arrays: lines are 64-byte aligned.
  logic unused_adr;
  assign unused_adr = ^{miss_adr[5:0], inv_adr[AWID-1:6+IW], inv_adr[5:0]};

  // Lowest-numbered free way at the missing index.
  always_comb begin
    free_found = 1'b0;
    free_way   = '0;
    for (int w = WAYS-1; w >= 0; w--) begin
      if (!valid_q[w][miss_idx]) begin
        free_found = 1'b1;
        free_way   = WW'(w);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    tag_d     = tag_q;
    way_d     = way_q;
    rr_d      = rr_q;
    allv_d    = allv_q;
    line_d    = line_q;
    valid_d   = valid_q;
    mem_req_d = mem_req_q;
    mem_adr_d = mem_adr_q;
    wr_en_d   = 1'b0;
    done_d    = 1'b0;
    err_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (miss) begin
          tag_d     = miss_adr[AWID-1:6];
          way_d     = free_found ? free_way : rr_q;
          allv_d    = !free_found;
          beat_d    = 2'd0;
          mem_req_d = 1'b1;
          mem_adr_d = {miss_adr[AWID-1:6], 6'b0};
          state_d   = FETCH;
        end
      end
      FETCH: begin
        if (mem.mem_ack) begin
          if (mem.mem_err) begin
            mem_req_d = 1'b0;
            err_d     = 1'b1;
            beat_d    = 2'd0;
            state_d   = IDLE;
          end else begin
            line_d[beat_q] = mem.mem_dat;
            beat_d         = beat_inc;
            if (beat_q == 2'd3) begin
              mem_req_d = 1'b0;
              wr_en_d   = 1'b1;
              done_d    = 1'b1;
              state_d   = WRITE;
            end else begin
              mem_adr_d = {tag_q, beat_inc, 4'b0};
            end
          end
        end
      end
      WRITE: begin
        valid_d[way_q][tag_q[IW-1:0]] = 1'b1;
        if (allv_q) rr_d = rr_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Invalidation is applied last so it overrides a same-cycle fill.
    if (invline) begin
      for (int w = 0; w < WAYS; w++) valid_d[w][inv_idx] = 1'b0;
    end
    if (invall) valid_d = '0;

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      beat_q    <= '0;
      tag_q     <= '0;
      way_q     <= '0;
      rr_q      <= '0;
      allv_q    <= 1'b0;
      line_q    <= '0;
      valid_q   <= '0;
      mem_req_q <= 1'b0;
      mem_adr_q <= '0;
      wr_en_q   <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      tag_q     <= tag_d;
      way_q     <= way_d;
      rr_q      <= rr_d;
      allv_q    <= allv_d;
      line_q    <= line_d;
      valid_q   <= valid_d;
      mem_req_q <= mem_req_d;
      mem_adr_q <= mem_adr_d;
      wr_en_q   <= wr_en_d;
      done_q    <= done_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
    end
  end

  assign mem.mem_req = mem_req_q;
  assign mem.mem_adr = mem_adr_q;
  assign wr_en       = wr_en_q;
  assign wr_way      = way_q;
  assign wr_idx      = tag_q[IW-1:0];
  assign wr_tag      = tag_q;
  assign wr_line     = line_q;
  assign valid       = valid_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;

endmodule

// File: tb/tb_rfphoenix_icache_fill.sv
// Directed bench for the I$ fill controller with a small valid/round-robin model.
module tb_rfphoenix_icache_fill;
  logic            clk = 1'b0;
  logic            rst, miss, invall, invline;
  logic [31:0]     miss_adr, inv_adr;
  logic            wr_en, busy, done, err;
  logic [1:0]      wr_way;
  logic [6:0]      wr_idx;
  logic [25:0]     wr_tag;
  logic [511:0]    wr_line;
  logic [3:0][127:0] valid;

  logic [3:0][127:0] exp_valid;
  logic [1:0]        exp_rr;
  int total = 0;
  int bad   = 0;

  rfphoenix_icache_fill_if #(.AWID(32)) m ();

  rfphoenix_icache_fill dut (
    .clk(clk), .rst(rst), .miss(miss), .miss_adr(miss_adr),
    .invall(invall), .invline(invline), .inv_adr(inv_adr), .mem(m),
    .wr_en(wr_en), .wr_way(wr_way), .wr_idx(wr_idx), .wr_tag(wr_tag),
    .wr_line(wr_line), .valid(valid), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int victim(input logic [6:0] idx);
    for (int w = 0; w < 4; w++) if (!exp_valid[w][idx]) return w;
    return int'(exp_rr);
  endfunction

  function automatic logic [127:0] beat_dat(input logic [31:0] adr, input int b);
    return {adr, 32'h5A5A_0000 + 32'(b), 32'hC0DE_0000 ^ adr, 32'hA0 + 32'(b)};
  endfunction

  // One miss/fill. err_beat<0: no error; inv_wr: invline on the WRITE cycle;
  // ia_fetch: invall together with the beat-1 ack.
  task automatic fill(input logic [31:0] adr, input int waits, input int err_beat,
                      input bit inv_wr, input bit ia_fetch);
    logic [31:0]  base;
    logic [6:0]   idx;
    logic [511:0] exp_line;
    int           w;
    bit           full;
    base     = {adr[31:6], 6'b0};
    idx      = adr[12:6];
    w        = victim(idx);
    full     = &{exp_valid[0][idx], exp_valid[1][idx], exp_valid[2][idx], exp_valid[3][idx]};
    exp_line = '0;
    miss = 1'b1; miss_adr = adr;
    tick();
    miss = 1'b0;
    chk("req_first", 512'(m.mem_req), 512'(1'b1));
    chk("adr_first", 512'(m.mem_adr), 512'(base));
    chk("busy_fetch", 512'(busy), 512'(1'b1));
    tick();
    for (int b = 0; b < 4; b++) begin
      for (int k = 0; k < waits; k++) begin
        chk("req_hold", 512'(m.mem_req), 512'(1'b1));
        chk("adr_hold", 512'(m.mem_adr), 512'(base + 32'(16 * b)));
        chk("wren_early", 512'(wr_en), 512'(1'b0));
        tick();
      end
      m.mem_ack = 1'b1;
      m.mem_dat = beat_dat(adr, b);
      m.mem_err = (b == err_beat);
      if (ia_fetch && b == 1) invall = 1'b1;
      chk("adr_beat", 512'(m.mem_adr), 512'(base + 32'(16 * b)));
      chk("wren_beat", 512'(wr_en), 512'(1'b0));
      exp_line[128*b +: 128] = beat_dat(adr, b);
      tick();
      m.mem_ack = 1'b0; m.mem_err = 1'b0; invall = 1'b0;
      if (ia_fetch && b == 1) exp_valid = '0;
      if (b == err_beat) begin
        chk("err_pulse", 512'(err), 512'(1'b1));
        chk("err_busy", 512'(busy), 512'(1'b0));
        chk("err_req", 512'(m.mem_req), 512'(1'b0));
        chk("err_nowr", 512'(wr_en), 512'(1'b0));
        chk("err_valid", 512'(valid), 512'(exp_valid));
        tick();
        chk("err_once", 512'(err), 512'(1'b0));
        chk("err_nowr2", 512'(wr_en), 512'(1'b0));
        return;
      end
    end
    if (inv_wr) begin invline = 1'b1; inv_adr = adr; end
    chk("wr_en", 512'(wr_en), 512'(1'b1));
    chk("done", 512'(done), 512'(1'b1));
    chk("req_drop", 512'(m.mem_req), 512'(1'b0));
    chk("wr_way", 512'(wr_way), 512'(w));
    chk("wr_idx", 512'(wr_idx), 512'(idx));
    chk("wr_tag", 512'(wr_tag), 512'(adr[31:6]));
    chk("wr_line", wr_line, exp_line);
    tick();
    invline = 1'b0;
    if (inv_wr) for (int v = 0; v < 4; v++) exp_valid[v][idx] = 1'b0;
    else exp_valid[w][idx] = 1'b1;
    if (full) exp_rr = exp_rr + 2'd1;
    chk("wr_en_off", 512'(wr_en), 512'(1'b0));
    chk("done_off", 512'(done), 512'(1'b0));
    chk("busy_idle", 512'(busy), 512'(1'b0));
    chk("valid", 512'(valid), 512'(exp_valid));
  endtask

  initial begin
    rst = 1'b1; miss = 1'b0; invall = 1'b0; invline = 1'b0;
    miss_adr = '0; inv_adr = '0;
    m.mem_ack = 1'b0; m.mem_err = 1'b0; m.mem_dat = '0;
    exp_valid = '0; exp_rr = '0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_req", 512'(m.mem_req), 512'(1'b0));
    chk("rst_adr", 512'(m.mem_adr), 512'(0));
    chk("rst_busy", 512'(busy), 512'(1'b0));
    chk("rst_outs", 512'({wr_en, done, err}), 512'(3'b000));
    chk("rst_valid", 512'(valid), 512'(0));

    // Cold fill, then fill the remaining ways of index 0x49.
    fill(32'h0000_1240, 0, -1, 1'b0, 1'b0);
    fill(32'h0000_3240, 0, -1, 1'b0, 1'b0);
    fill(32'h0000_7240, 0, -1, 1'b0, 1'b0);
    fill(32'h0000_9240, 0, -1, 1'b0, 1'b0);
    // Set full: round-robin picks way 0, then way 1.
    fill(32'h0000_5240, 0, -1, 1'b0, 1'b0);
    fill(32'h0000_B240, 0, -1, 1'b0, 1'b0);

    // Wait states between acks.
    fill(32'h0000_0080, 3, -1, 1'b0, 1'b0);

    // Bus error on beat 2, then a clean retry from beat 0.
    fill(32'h0000_0100, 0, 2, 1'b0, 1'b0);
    fill(32'h0000_0100, 1, -1, 1'b0, 1'b0);

    // invline on the WRITE cycle at the full index: whole set ends invalid.
    fill(32'h0000_1240, 0, -1, 1'b1, 1'b0);
    // invall during FETCH: fill still completes, only its own bit set.
    fill(32'h0000_0180, 0, -1, 1'b0, 1'b1);

    // Clear, then reset in the middle of beat 1.
    invall = 1'b1; tick(); invall = 1'b0; exp_valid = '0;
    chk("invall_idle", 512'(valid), 512'(0));
    miss = 1'b1; miss_adr = 32'h0000_01C0;
    tick(); miss = 1'b0;
    tick();
    m.mem_ack = 1'b1; m.mem_dat = beat_dat(32'h0000_01C0, 0);
    tick(); m.mem_ack = 1'b0;
    rst = 1'b1;
    tick(); rst = 1'b0;
    exp_rr = '0;
    chk("midrst_req", 512'(m.mem_req), 512'(1'b0));
    chk("midrst_busy", 512'(busy), 512'(1'b0));
    chk("midrst_wr", 512'(wr_en), 512'(1'b0));
    chk("midrst_valid", 512'(valid), 512'(exp_valid));
    for (int k = 0; k < 6; k++) begin
      chk("midrst_quiet", 512'({wr_en, done, busy}), 512'(3'b000));
      tick();
    end
    fill(32'h0000_01C0, 0, -1, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
